// File: rtl/thread_sched.sv
// thread_sched: round-robin fetch scheduler for a barrel-threaded core.
// Each cycle it picks the next eligible hardware thread after the last one
// issued and registers that thread's PC as the fetch slot.
//
// A thread is eligible when it is enabled, has no instruction in flight and
// is not halted. The execute stage reports each outcome on the resolve
// port. That port clears the in-flight bit, can redirect the PC on a taken
// branch, and can halt the thread.
//
// Optional build macro: THREAD_SCHED_PERF_EN adds 32-bit wrapping
// performance counters. Without it, perf_cnt is tied to zero.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   stall             hold issue this cycle
//   thread_en         per-thread enable mask
//   resolve_*         outcome of one in-flight instruction (tid, taken,
//                     target pc, halt)
//   issue_valid/tid/pc/pc_plus4
//                     registered fetch slot
//   busy_mask         threads with an instruction in flight
//   halted_mask       halted threads
//   perf_sel          counter select: thread id, or NUM_THREADS for idle
//                     cycles
//   perf_cnt          selected counter, registered
module thread_sched #(
  parameter int unsigned NUM_THREADS   = 8,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [NUM_THREADS-1:0]     thread_en,
  input  logic                       resolve_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] resolve_tid,
  input  logic                       resolve_taken,
  input  logic [ADDRESS_WIDTH-1:0]   resolve_pc,
  input  logic                       resolve_halt,
  output logic                       issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
  output logic [ADDRESS_WIDTH-1:0]   issue_pc,
  output logic [ADDRESS_WIDTH-1:0]   issue_pc_plus4,
  output logic [NUM_THREADS-1:0]     busy_mask,
  output logic [NUM_THREADS-1:0]     halted_mask,
  input  logic [$clog2(NUM_THREADS):0] perf_sel,
  output logic [31:0]                perf_cnt
);

  localparam int unsigned BT = $clog2(NUM_THREADS);
  localparam int unsigned SW = BT + 1;
  localparam int unsigned CW = 32;

  // Per-thread architectural state
  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]   busy_q, busy_d;
  logic [NUM_THREADS-1:0]   halted_q, halted_d;
  logic [BT-1:0]            last_q, last_d;

  // Next values of the registered fetch slot
  logic                     issue_valid_d;
  logic [BT-1:0]            issue_tid_d;
  logic [ADDRESS_WIDTH-1:0] issue_pc_d;
  logic [ADDRESS_WIDTH-1:0] issue_pc_plus4_d;

  // Arbitration results
  logic [NUM_THREADS-1:0]   eligible;
  logic                     pick_found;
  logic [BT-1:0]            pick_tid;
  logic [BT-1:0]            cand;
  logic                     do_issue;
  logic [ADDRESS_WIDTH-1:0] pick_pc;
  logic [ADDRESS_WIDTH-1:0] pick_pc4;
  logic                     resolve_hit;

  // Rotating priority pick, starting one past the last thread issued.
  // Eligibility uses registered busy, so a resolve in this cycle cannot
  // make its thread eligible until the next cycle.
  always_comb begin
    eligible   = thread_en & ~busy_q & ~halted_q;
    pick_found = 1'b0;
    pick_tid   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      cand = last_q + BT'(i);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_tid   = cand;
      end
    end
    do_issue = ~stall & pick_found;
    pick_pc  = pc_q[pick_tid];
    pick_pc4 = pick_pc + ADDRESS_WIDTH'(4);
  end

  // Resolve acts only on a thread that really has an instruction in flight
  assign resolve_hit = resolve_valid & busy_q[resolve_tid];

  // Next-state logic for thread state and the fetch slot
  always_comb begin
    pc_d             = pc_q;
    busy_d           = busy_q;
    halted_d         = halted_q;
    last_d           = last_q;
    issue_valid_d    = 1'b0;
    issue_tid_d      = issue_tid;
    issue_pc_d       = issue_pc;
    issue_pc_plus4_d = issue_pc_plus4;

    // The issued thread was not busy and the resolved thread was, so
    // these two updates never target the same thread.
    if (do_issue) begin
      busy_d[pick_tid] = 1'b1;
      pc_d[pick_tid]   = pick_pc4;
      last_d           = pick_tid;
      issue_valid_d    = 1'b1;
      issue_tid_d      = pick_tid;
      issue_pc_d       = pick_pc;
      issue_pc_plus4_d = pick_pc4;
    end

    // A halt wins over a taken redirect and leaves the PC alone
    if (resolve_hit) begin
      busy_d[resolve_tid] = 1'b0;
      if (resolve_halt) begin
        halted_d[resolve_tid] = 1'b1;
      end else if (resolve_taken) begin
        pc_d[resolve_tid] = resolve_pc;
      end
    end

    // A disabled thread is held at its start PC with halt cleared.
    // Its busy bit is still released only by a resolve.
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (!thread_en[t]) begin
        pc_d[t]     = RESET_PC;
        halted_d[t] = 1'b0;
      end
    end
  end

  // State and fetch-slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC;
      end
      busy_q         <= '0;
      halted_q       <= '0;
      last_q         <= BT'(NUM_THREADS - 1);
      issue_valid    <= 1'b0;
      issue_tid      <= '0;
      issue_pc       <= '0;
      issue_pc_plus4 <= '0;
    end else begin
      pc_q           <= pc_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      last_q         <= last_d;
      issue_valid    <= issue_valid_d;
      issue_tid      <= issue_tid_d;
      issue_pc       <= issue_pc_d;
      issue_pc_plus4 <= issue_pc_plus4_d;
    end
  end

  assign busy_mask   = busy_q;
  assign halted_mask = halted_q;

`ifdef THREAD_SCHED_PERF_EN
  // Issue count per thread and a count of cycles with no issue.
  // All counters wrap.
  logic [CW-1:0] issue_cnt_q [NUM_THREADS];
  logic [CW-1:0] idle_cnt_q;
  logic [CW-1:0] perf_sel_val;
  logic [CW-1:0] perf_cnt_q;

  // Counter read mux; select values above NUM_THREADS read zero
  always_comb begin
    perf_sel_val = '0;
    if (perf_sel < SW'(NUM_THREADS)) begin
      perf_sel_val = issue_cnt_q[perf_sel[BT-1:0]];
    end else if (perf_sel == SW'(NUM_THREADS)) begin
      perf_sel_val = idle_cnt_q;
    end
  end

  // Counter registers and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        issue_cnt_q[t] <= '0;
      end
      idle_cnt_q <= '0;
      perf_cnt_q <= '0;
    end else begin
      if (do_issue) begin
        issue_cnt_q[pick_tid] <= issue_cnt_q[pick_tid] + CW'(1);
      end else begin
        idle_cnt_q <= idle_cnt_q + CW'(1);
      end
      perf_cnt_q <= perf_sel_val;
    end
  end

  assign perf_cnt = perf_cnt_q;
`else
  // Counters are absent; the select input is deliberately unused
  logic unused_perf_sel;
  assign unused_perf_sel = ^perf_sel;
  assign perf_cnt        = CW'(0);
`endif

endmodule

// File: tb/tb_thread_sched.sv
// Bench for thread_sched (default parameters: 8 threads, 32-bit PC,
// RESET_PC 0).
// A queue- and array-based reference model predicts every output each
// cycle. Directed scenarios add explicit expected values.
module tb_thread_sched;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [7:0]  thread_en;
  logic        resolve_valid;
  logic [2:0]  resolve_tid;
  logic        resolve_taken;
  logic [31:0] resolve_pc;
  logic        resolve_halt;
  logic        issue_valid;
  logic [2:0]  issue_tid;
  logic [31:0] issue_pc;
  logic [31:0] issue_pc_plus4;
  logic [7:0]  busy_mask;
  logic [7:0]  halted_mask;
  logic [3:0]  perf_sel;
  logic [31:0] perf_cnt;

  thread_sched dut (
    .clk(clk), .rst(rst), .stall(stall), .thread_en(thread_en),
    .resolve_valid(resolve_valid), .resolve_tid(resolve_tid),
    .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
    .resolve_halt(resolve_halt), .issue_valid(issue_valid),
    .issue_tid(issue_tid), .issue_pc(issue_pc),
    .issue_pc_plus4(issue_pc_plus4), .busy_mask(busy_mask),
    .halted_mask(halted_mask), .perf_sel(perf_sel), .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  bit [31:0] m_pc [N];
  bit        m_busy [N];
  bit        m_halted [N];
  int        m_last;
  bit [31:0] m_icnt [N];
  bit [31:0] m_idle;

  // Model predictions for the current cycle
  bit        exp_valid;
  int        exp_tid;
  bit [31:0] exp_pc, exp_pc4, exp_perf;
  bit [7:0]  exp_busy, exp_halted;

  // Auto-resolver: replays each observed issue a fixed delay later
  bit auto_res;
  int pend_tid[$];
  int pend_due[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < N; t++) begin
      m_pc[t] = 0; m_busy[t] = 0; m_halted[t] = 0; m_icnt[t] = 0;
    end
    m_last = N - 1;
    m_idle = 0;
    pend_tid.delete();
    pend_due.delete();
  endtask

  // One clock edge of the reference model, driven by the inputs applied now
  task automatic model_edge();
    int pick;
    pick = -1;
    if (!stall) begin
      for (int k = 1; k <= N; k++) begin
        int t;
        t = (m_last + k) % N;
        if (pick < 0 && thread_en[t] && !m_busy[t] && !m_halted[t]) pick = t;
      end
    end
`ifdef THREAD_SCHED_PERF_EN
    if (perf_sel < N) exp_perf = m_icnt[perf_sel];
    else if (perf_sel == N) exp_perf = m_idle;
    else exp_perf = 0;
    if (pick >= 0) m_icnt[pick] = m_icnt[pick] + 1;
    else m_idle = m_idle + 1;
`else
    exp_perf = 0;
`endif
    exp_valid = (pick >= 0);
    if (resolve_valid && m_busy[resolve_tid]) begin
      m_busy[resolve_tid] = 0;
      if (resolve_halt) m_halted[resolve_tid] = 1;
      else if (resolve_taken) m_pc[resolve_tid] = resolve_pc;
    end
    if (pick >= 0) begin
      exp_tid     = pick;
      exp_pc      = m_pc[pick];
      exp_pc4     = m_pc[pick] + 4;
      m_pc[pick]  = m_pc[pick] + 4;
      m_busy[pick] = 1;
      m_last      = pick;
    end
    for (int t = 0; t < N; t++) begin
      if (!thread_en[t]) begin
        m_pc[t] = 0;
        m_halted[t] = 0;
      end
      exp_busy[t]   = m_busy[t];
      exp_halted[t] = m_halted[t];
    end
  endtask

  // Advance one cycle and compare against the model
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("issue_valid", 64'(issue_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("issue_tid", 64'(issue_tid), 64'(exp_tid));
      chk("issue_pc", 64'(issue_pc), 64'(exp_pc));
      chk("issue_pc_plus4", 64'(issue_pc_plus4), 64'(exp_pc4));
    end
    chk("busy_mask", 64'(busy_mask), 64'(exp_busy));
    chk("halted_mask", 64'(halted_mask), 64'(exp_halted));
    chk("perf_cnt", 64'(perf_cnt), 64'(exp_perf));
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    resolve_halt  = 1'b0;
    if (auto_res) begin
      if (issue_valid) begin
        pend_tid.push_back(int'(issue_tid));
        pend_due.push_back(cyc + 2);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        resolve_valid = 1'b1;
        resolve_tid   = 3'(pend_tid.pop_front());
        void'(pend_due.pop_front());
      end
    end
  endtask

  // Asynchronous reset, with its effect checked before any clock edge
  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_tid", 64'(issue_tid), 64'd0);
    chk("rst_issue_pc", 64'(issue_pc), 64'd0);
    chk("rst_issue_pc_plus4", 64'(issue_pc_plus4), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_halted", 64'(halted_mask), 64'd0);
    chk("rst_perf", 64'(perf_cnt), 64'd0);
    model_reset();
    auto_res = 1'b0;
    stall = 1'b0;
    resolve_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; thread_en = 8'h00; resolve_valid = 1'b0;
    resolve_tid = 3'd0; resolve_taken = 1'b0; resolve_pc = 32'd0;
    resolve_halt = 1'b0; perf_sel = 4'd0; auto_res = 1'b0;
    #3;
    do_reset();

    // Full rotation with resolves three cycles after issue
    thread_en = 8'hFF;
    auto_res  = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("rot_valid", 64'(issue_valid), 64'd1);
      chk("rot_tid", 64'(issue_tid), 64'(n % 8));
      chk("rot_pc", 64'(issue_pc), (n < 8) ? 64'd0 : 64'd4);
    end

    // Stall while the remaining resolves drain, then resume rotation
    stall    = 1'b1;
    perf_sel = 4'd2;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("stall_valid", 64'(issue_valid), 64'd0);
`ifdef THREAD_SCHED_PERF_EN
      if (n == 0) chk("perf_tid2", 64'(perf_cnt), 64'd2);
`else
      if (n == 0) chk("perf_off", 64'(perf_cnt), 64'd0);
`endif
    end
    chk("stall_busy_clear", 64'(busy_mask), 64'd0);
    stall = 1'b0;
    step();
    chk("resume_tid", 64'(issue_tid), 64'd0);
    chk("resume_pc", 64'(issue_pc), 64'd8);

    // Two threads, thread 0 left unresolved
    do_reset();
    thread_en = 8'h05;
    step(); chk("en05_tid0", 64'(issue_tid), 64'd0);
    step(); chk("en05_tid2", 64'(issue_tid), 64'd2);
    for (int n = 0; n < 3; n++) begin
      step(); chk("en05_idle", 64'(issue_valid), 64'd0);
    end
    resolve_valid = 1'b1; resolve_tid = 3'd0;
    step(); chk("en05_same_cycle", 64'(issue_valid), 64'd0);
    step();
    chk("en05_reissue_valid", 64'(issue_valid), 64'd1);
    chk("en05_reissue_tid", 64'(issue_tid), 64'd0);
    chk("en05_reissue_pc", 64'(issue_pc), 64'd4);

    // Taken branch redirect on thread 3
    do_reset();
    thread_en = 8'h08;
    step(); chk("br_first_tid", 64'(issue_tid), 64'd3);
    resolve_valid = 1'b1; resolve_tid = 3'd3; resolve_taken = 1'b1;
    resolve_pc = 32'h100;
    step();
    step();
    chk("br_pc", 64'(issue_pc), 64'h100);
    chk("br_pc4", 64'(issue_pc_plus4), 64'h104);

    // Halt thread 1, then revive it through its enable
    do_reset();
    thread_en = 8'h02;
    step();
    resolve_valid = 1'b1; resolve_tid = 3'd1; resolve_halt = 1'b1;
    step(); chk("halt_mask", 64'(halted_mask), 64'h02);
    step(); chk("halt_skip", 64'(issue_valid), 64'd0);
    thread_en = 8'h00;
    step(); chk("halt_cleared", 64'(halted_mask), 64'd0);
    thread_en = 8'h02;
    step();
    chk("revive_tid", 64'(issue_tid), 64'd1);
    chk("revive_pc", 64'(issue_pc), 64'd0);

    // Randomized traffic, with a mid-run reset and a stale resolve
    do_reset();
    thread_en = 8'hFF;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        thread_en = 8'hFF;
        resolve_valid = 1'b1; resolve_tid = 3'd0; resolve_taken = 1'b1;
        resolve_pc = 32'h200;
        step();
        continue;
      end
      stall    = ($urandom_range(0, 7) == 0);
      perf_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) thread_en = thread_en ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) thread_en = 8'hFF;
      if ($urandom_range(0, 3) != 0) begin
        int r;
        r = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0) begin
          for (int k = 0; k < N; k++) begin
            if (!m_busy[r]) r = (r + 1) % N;
          end
        end
        resolve_valid = 1'b1;
        resolve_tid   = 3'(r);
        resolve_taken = ($urandom_range(0, 3) == 0);
        resolve_halt  = ($urandom_range(0, 15) == 0);
        resolve_pc    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thread_sched.md
THREAD_SCHED -- requirements
Module: thread_sched

Interface
REQ-001 Parameters SHALL be:
- NUM_THREADS, 8, hardware thread count, power of two, 2..32
- ADDRESS_WIDTH, 32, PC width
- RESET_PC, 0, start PC of every thread
REQ-002 Ports SHALL be (BT = $clog2(NUM_THREADS)):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold issue this cycle
- thread_en  in  NUM_THREADS  per-thread enable mask
- resolve_valid  in  1  execute reports an instruction outcome
- resolve_tid  in  BT  thread of that instruction
- resolve_taken  in  1  branch/jump taken
- resolve_pc  in  ADDRESS_WIDTH  taken target
- resolve_halt  in  1  instruction was a halt
- issue_valid  out  1  fetch slot valid
- issue_tid  out  BT  thread issued
- issue_pc  out  ADDRESS_WIDTH  PC issued
- issue_pc_plus4  out  ADDRESS_WIDTH  issue_pc + 4
- busy_mask  out  NUM_THREADS  threads with an instruction in flight
- halted_mask  out  NUM_THREADS  halted threads
- perf_sel  in  BT+1  counter select
- perf_cnt  out  32  selected counter

Function
REQ-003 Per thread t the block SHALL hold pc[t], busy[t], halted[t]; eligible[t] = thread_en[t] & ~busy[t] & ~halted[t], all from registered state.
REQ-004 Each cycle with stall=0 and any eligible thread, the block SHALL pick the first eligible thread scanning upward from last_tid+1 with wrap-around from NUM_THREADS-1 to 0, and register issue_valid=1, issue_tid, issue_pc=pc[t], issue_pc_plus4=pc[t]+4 (modulo 2^ADDRESS_WIDTH) on the next edge; latency one cycle.
REQ-005 On issue the block SHALL set busy[t], set pc[t]=pc[t]+4, and set last_tid=t.
REQ-006 With stall=1 or no eligible thread, issue_valid SHALL be 0 next cycle and last_tid, pc, busy SHALL be unchanged by issue logic.
REQ-007 resolve_valid with busy[resolve_tid]=1 SHALL clear busy; if resolve_taken, pc[resolve_tid]=resolve_pc; if resolve_halt, halted set and pc unchanged.
REQ-008 resolve_valid with busy[resolve_tid]=0 SHALL be ignored entirely.
REQ-009 Resolve SHALL be processed regardless of stall.
REQ-010 Resolve clearing busy[t] SHALL NOT make t eligible in the same cycle; earliest reissue is the following cycle.
REQ-011 thread_en[t]=0 SHALL force pc[t]=RESET_PC and clear halted[t]; busy[t] still clears only via resolve.
REQ-012 With all threads enabled and resolves arriving within NUM_THREADS-1 cycles, issue SHALL be strict rotation 0,1,...,NUM_THREADS-1,0.

Reset
REQ-013 rst low SHALL asynchronously set pc[*]=RESET_PC, busy=0, halted=0, last_tid=NUM_THREADS-1, issue_valid=0, issue_tid=0, issue_pc=0, issue_pc_plus4=0, all counters 0; first issue after release SHALL be thread 0.
REQ-014 Reset mid-operation SHALL discard in-flight state; later resolves for pre-reset issues are ignored per REQ-008.

Configuration
REQ-015 Macro THREAD_SCHED_PERF_EN SHALL, when defined, add 32-bit wrapping counters: per-thread issue count (perf_sel=t) and no-issue cycle count (perf_sel=NUM_THREADS); other perf_sel values read 0.
REQ-016 Without THREAD_SCHED_PERF_EN, counters SHALL not exist and perf_cnt SHALL be constant 0; all other behaviour identical.

Verification
REQ-017 Reset release, thread_en=0xFF, resolve each tid 3 cycles after issue -> issue_tid 0..7 repeating, issue_pc 0 for first 8 issues, then 4.
REQ-018 thread_en=0x05, no resolve for tid 0 -> tid 2 issues, then issue_valid=0 until tid 0 resolves; tid 0 reissues one cycle after resolve.
REQ-019 Resolve tid 3 taken resolve_pc=0x100 -> next issue of tid 3 has issue_pc=0x100, issue_pc_plus4=0x104.
REQ-020 Resolve tid 1 resolve_halt=1 -> halted_mask bit1 set, tid 1 skipped; thread_en[1] 0 then 1 -> tid 1 reissues at RESET_PC.
REQ-021 stall=1 for 4 cycles with resolves arriving -> issue_valid=0 throughout, busy bits clear, rotation resumes from last_tid+1.
REQ-022 With THREAD_SCHED_PERF_EN, 16 issue cycles on 8 threads then perf_sel=2 -> perf_cnt=2; without macro perf_cnt=0.
